// File: rtl/multicycle_cpu_if.sv
// rtl/multicycle_cpu_if.sv - instruction handshake bus for multicycle_cpu
interface multicycle_cpu_if #(
   parameter int INSTR_WIDTH = 20
);
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   instr_valid;
   logic                   instr_ready;

   modport master (
      output instruction,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  instruction,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - five-state multicycle CPU with register file and data memory
module multicycle_cpu #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5,
   parameter int REG_BITS   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_cpu_if.slave       bus,
   input  logic [REG_BITS-1:0]   dbg_sel,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  flag_z,
   output logic                  flag_c,
   output logic                  retired,
   output logic                  illegal
);
   localparam int INSTR_WIDTH = 4 + 2*REG_BITS + 2 + DATA_WIDTH;
   localparam int NREGS       = 1 << REG_BITS;
   localparam int DEPTH       = 1 << ADDR_BITS;
   localparam int SH_BITS     = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_MOV = 4'd7;
   localparam logic [3:0] OP_LD  = 4'd8;
   localparam logic [3:0] OP_ST  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   state_t state;

   logic [INSTR_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0]  regs [NREGS];
   logic [DATA_WIDTH-1:0]  mem  [DEPTH];

   logic                   ready_q;
   logic [DATA_WIDTH-1:0]  a_q;
   logic [DATA_WIDTH-1:0]  b_q;
   logic [DATA_WIDTH-1:0]  s_q;
   logic [DATA_WIDTH-1:0]  alu_q;
   logic                   c_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]  mem_q;

   // Fields of the latched instruction word, MSB first
   logic [3:0]            op_f;
   logic [REG_BITS-1:0]   rd_f;
   logic [REG_BITS-1:0]   ra_f;
   logic                  imm_f;
   logic [DATA_WIDTH-1:0] low_f;
   logic                  unused_flag0;

   assign op_f         = ir[INSTR_WIDTH-1 -: 4];
   assign rd_f         = ir[INSTR_WIDTH-5 -: REG_BITS];
   assign ra_f         = ir[INSTR_WIDTH-5-REG_BITS -: REG_BITS];
   assign imm_f        = ir[DATA_WIDTH+1];
   assign unused_flag0 = ir[DATA_WIDTH];
   assign low_f        = ir[DATA_WIDTH-1:0];

   assign bus.instr_ready = ready_q;

   logic [DATA_WIDTH-1:0] rf_a;
   logic [DATA_WIDTH-1:0] rf_b;
   logic [DATA_WIDTH-1:0] rf_s;
   logic [DATA_WIDTH-1:0] op_b;

   // Register file read ports; r0 is hard-wired to zero
   always_comb begin
      rf_a     = (ra_f == '0) ? '0 : regs[ra_f];
      rf_b     = (low_f[REG_BITS-1:0] == '0) ? '0 : regs[low_f[REG_BITS-1:0]];
      rf_s     = (rd_f == '0) ? '0 : regs[rd_f];
      op_b     = imm_f ? low_f : rf_b;
      dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];
   end

   logic [DATA_WIDTH:0]   sum;
   logic [SH_BITS-1:0]    sh;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_c;
   logic [DATA_WIDTH-1:0] wb_val;

   // ALU on the operands captured in DECODE; sum doubles as the address adder
   always_comb begin
      sum     = {1'b0, a_q} + {1'b0, b_q};
      sh      = b_q[SH_BITS-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_f)
         OP_ADD: begin
            alu_res = sum[DATA_WIDTH-1:0];
            alu_c   = sum[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_res = a_q - b_q;
            alu_c   = (a_q < b_q);
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SHL:  alu_res = a_q << sh;
         OP_SHR:  alu_res = a_q >> sh;
         OP_MOV:  alu_res = b_q;
         default: alu_res = '0;
      endcase
      wb_val = (op_f == OP_LD) ? mem_q : alu_q;
   end

   // Control FSM, datapath registers, register file, memory and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         retired <= 1'b0;
         illegal <= 1'b0;
         result  <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         ir      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         alu_q   <= '0;
         c_q     <= 1'b0;
         addr_q  <= '0;
         mem_q   <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.instr_valid && ready_q) begin
                  ir      <= bus.instruction;
                  ready_q <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q   <= rf_a;
               b_q   <= op_b;
               s_q   <= rf_s;
               state <= S_EXEC;
            end
            S_EXEC: begin
               alu_q  <= alu_res;
               c_q    <= alu_c;
               addr_q <= sum[ADDR_BITS-1:0];
               if (op_f == OP_LD || op_f == OP_ST) begin
                  state <= S_MEM;
               end else begin
                  state   <= S_WB;
                  retired <= 1'b1;
               end
            end
            S_MEM: begin
               if (op_f == OP_ST) mem[addr_q] <= s_q;
               mem_q   <= mem[addr_q];
               state   <= S_WB;
               retired <= 1'b1;
            end
            S_WB: begin
               retired <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
               if (op_f <= OP_LD) begin
                  if (rd_f != '0) regs[rd_f] <= wb_val;
                  result <= wb_val;
                  flag_z <= (wb_val == '0);
                  if (op_f != OP_LD) flag_c <= c_q;
               end else if (op_f != OP_ST) begin
                  illegal <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               retired <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - scoreboard bench for multicycle_cpu
module tb_multicycle_cpu;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] dbg_sel = 3'd0;
   logic [7:0] dbg_data;
   logic [7:0] result;
   logic       flag_z;
   logic       flag_c;
   logic       retired;
   logic       illegal;

   multicycle_cpu_if #(.INSTR_WIDTH(20)) bus ();

   multicycle_cpu dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data),
      .result   (result),
      .flag_z   (flag_z),
      .flag_c   (flag_c),
      .retired  (retired),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Architectural reference model
   int mreg [8];
   int mmem [32];
   int m_res, m_z, m_c, m_ill;

   typedef struct {
      int acc;
      int lat;
      int rd;
      int rd_val;
      int res;
      int z;
      int c;
      int ill;
   } exp_t;

   exp_t q[$];

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) mreg[i] = 0;
      for (int i = 0; i < 32; i++) mmem[i] = 0;
      m_res = 0; m_z = 0; m_c = 0; m_ill = 0;
   endfunction

   function automatic logic [19:0] enc(input int op, input int rd, input int ra, input int imm, input int low);
      logic [19:0] w;
      w[19:16] = op[3:0];
      w[15:13] = rd[2:0];
      w[12:10] = ra[2:0];
      w[9]     = imm[0];
      w[8]     = 1'($urandom_range(0, 1));
      w[7:0]   = low[7:0];
      return w;
   endfunction

   // Executes one instruction on the model and queues what the DUT must show
   function automatic void model_apply(input logic [19:0] ins, input int acc);
      int op, rd, ra, imm, low, a, b, v, s;
      bit wr;
      exp_t e;
      op  = int'(ins[19:16]);
      rd  = int'(ins[15:13]);
      ra  = int'(ins[12:10]);
      imm = int'(ins[9]);
      low = int'(ins[7:0]);
      a   = mreg[ra];
      b   = imm ? low : mreg[low % 8];
      wr  = 1'b1;
      v   = 0;
      case (op)
         0: begin s = a + b; v = s % 256; m_c = (s > 255); end
         1: begin v = (a - b + 256) % 256; m_c = (a < b); end
         2: begin v = a & b; m_c = 0; end
         3: begin v = a | b; m_c = 0; end
         4: begin v = a ^ b; m_c = 0; end
         5: begin v = (a << (b % 8)) % 256; m_c = 0; end
         6: begin v = a >> (b % 8); m_c = 0; end
         7: begin v = b; m_c = 0; end
         8: v = mmem[(a + b) % 32];
         9: begin mmem[(a + b) % 32] = mreg[rd]; wr = 1'b0; end
         default: begin m_ill = 1; wr = 1'b0; end
      endcase
      if (wr) begin
         if (rd != 0) mreg[rd] = v;
         m_res = v;
         m_z   = (v == 0);
      end
      // retired fills the 3rd (ALU/NOP) or 4th (LD/ST) cycle after the accept edge
      e.acc    = acc;
      e.lat    = (op == 8 || op == 9) ? 3 : 2;
      e.rd     = rd;
      e.rd_val = mreg[rd];
      e.res    = m_res;
      e.z      = m_z;
      e.c      = m_c;
      e.ill    = m_ill;
      q.push_back(e);
   endfunction

   int acc_issued = 0;
   int acc_seen = 0;

   // Independent count of handshakes, sampled just after the falling edge
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (bus.instr_valid && bus.instr_ready && !rst) acc_seen++;
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept edge
   task automatic issue(input logic [19:0] ins, input bit hold, input bit track);
      int w = 0;
      bus.instruction = ins;
      bus.instr_valid = 1'b1;
      while (!bus.instr_ready) begin
         @(negedge clk);
         w++;
         if (w > 50) begin
            chk("accept_timeout", 0, 1);
            bus.instr_valid = 1'b0;
            return;
         end
      end
      if (track) model_apply(ins, cyc + 1);
      acc_issued++;
      @(negedge clk);
      if (!hold) bus.instr_valid = 1'b0;
   endtask

   // Monitor: pops an expectation whenever the DUT retires
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (retired === 1'b1) begin
            if (q.size() == 0) begin
               chk("spurious_retire", 1, 0);
            end else begin
               e = q.pop_front();
               chk("retire_latency", cyc - e.acc, e.lat);
               dbg_sel = 3'(e.rd);
               @(negedge clk);
               #1;
               chk("retired_one_cycle", int'(retired), 0);
               chk("result", int'(result), e.res);
               chk("flag_z", int'(flag_z), e.z);
               chk("flag_c", int'(flag_c), e.c);
               chk("illegal", int'(illegal), e.ill);
               chk("reg_rd", int'(dbg_data), e.rd_val);
            end
         end
      end
   end

   task automatic drain();
      int w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_queue_empty", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   logic [19:0] dir [11];

   initial begin
      model_reset();
      bus.instruction = enc(7, 7, 0, 1, 8'hAA);
      bus.instr_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      chk("rst_ready", int'(bus.instr_ready), 1);
      chk("rst_result", int'(result), 0);
      chk("rst_flag_z", int'(flag_z), 0);
      chk("rst_flag_c", int'(flag_c), 0);
      chk("rst_retired", int'(retired), 0);
      chk("rst_illegal", int'(illegal), 0);
      @(negedge clk);

      dir[0]  = enc(7, 1, 0, 1, 8'h05);
      dir[1]  = enc(0, 2, 1, 1, 8'hFE);
      dir[2]  = enc(1, 3, 0, 1, 8'h01);
      dir[3]  = enc(2, 4, 3, 1, 8'h00);
      dir[4]  = enc(9, 2, 0, 1, 8'h1F);
      dir[5]  = enc(8, 5, 1, 1, 8'h1A);
      dir[6]  = enc(12, 6, 1, 1, 8'h33);
      dir[7]  = enc(0, 6, 2, 0, 8'h01);
      dir[8]  = enc(5, 7, 2, 1, 8'h09);
      dir[9]  = enc(6, 7, 3, 1, 8'h04);
      dir[10] = enc(0, 0, 3, 1, 8'h01);
      for (int i = 0; i < 11; i++) begin
         issue(dir[i], 1'b0, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      // Back-to-back random traffic with instr_valid held high
      for (int i = 0; i < 60; i++) begin
         issue(enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 255)), 1'b1, 1'b1);
      end
      bus.instr_valid = 1'b0;
      drain();

      // Reset while a store sits in MEM: store is dropped, state returns to IDLE
      issue(enc(7, 2, 0, 1, 8'h5A), 1'b0, 1'b1);
      issue(enc(9, 2, 0, 1, 8'h03), 1'b0, 1'b1);
      drain();
      issue(enc(7, 2, 0, 1, 8'h77), 1'b0, 1'b1);
      drain();
      issue(enc(9, 2, 0, 1, 8'h03), 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_ready", int'(bus.instr_ready), 1);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_flags", int'({flag_z, flag_c}), 0);
      chk("mid_rst_retired", int'(retired), 0);
      chk("mid_rst_illegal", int'(illegal), 0);
      @(negedge clk);
      issue(enc(8, 5, 0, 1, 8'h03), 1'b0, 1'b1);
      issue(enc(0, 1, 2, 1, 8'h00), 1'b0, 1'b1);
      drain();

      chk("accept_count", acc_seen, acc_issued);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end
endmodule
